// File: rtl/uart_tx.sv
// UART transmitter: byte in over valid/ready, out as start/8 data/[parity]/stop frame,
// LSB first, 16 x16_BAUD cycles per bit. serial_out is always a flop output.
module uart_tx #(
   parameter int P_STOP_BITS  = 1,
   parameter int P_PARITY_EN  = 0,
   parameter int P_PARITY_ODD = 0
) (
   input  logic       x16_BAUD,
   input  logic       reset,
   input  logic [7:0] Di,
   input  logic       load,
   output logic       ready,
   output logic       serial_out,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [2:0] LAST_STOP = 3'(P_STOP_BITS - 1);
   localparam logic       PAR_ODD   = (P_PARITY_ODD != 0);

   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic       par_q, par_d;
   logic       so_q, so_d;
   logic       wrap, accept;

   assign wrap       = (tick_q == 4'hF);
   assign ready      = (state_q == IDLE) || (state_q == STOP && wrap && bit_q == LAST_STOP);
   assign accept     = load && ready;
   assign busy       = (state_q != IDLE);
   assign serial_out = so_q;

   always_ff @(posedge x16_BAUD or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         so_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         so_q    <= so_d;
      end
   end

   // so_d is the line level for the state being entered, so the output flop
   // switches on the same edge as the state register.
   always_comb begin
      state_d = state_q;
      tick_d  = (state_q == IDLE) ? 4'd0 : tick_q + 4'd1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      so_d    = so_q;
      case (state_q)
         IDLE: begin
            so_d  = 1'b1;
            bit_d = '0;
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               bit_d   = '0;
               so_d    = sh_q[0];
            end
         end
         DATA: begin
            if (wrap) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (P_PARITY_EN != 0) begin
                     state_d = PARITY;
                     so_d    = par_q;
                  end else begin
                     state_d = STOP;
                     so_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  so_d  = sh_q[1];
               end
            end
         end
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
               bit_d   = '0;
               so_d    = 1'b1;
            end
         end
         STOP: begin
            if (wrap) begin
               so_d = 1'b1;
               if (bit_q == LAST_STOP) state_d = IDLE;
               else                    bit_d   = bit_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            so_d    = 1'b1;
         end
      endcase
      // A load in the last stop cycle overrides the return to IDLE.
      if (accept) begin
         state_d = START;
         tick_d  = '0;
         bit_d   = '0;
         sh_d    = Di;
         par_d   = (^Di) ^ PAR_ODD;
         so_d    = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations side by side, a vector table, hand
// sequences for reset/back-to-back/load-while-busy, and random frames vs a bit-list model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] di;
   logic [3:0] ld, so, rdy, bsy;

   always #5 clk = ~clk;

   uart_tx #(.P_STOP_BITS(1), .P_PARITY_EN(0), .P_PARITY_ODD(0)) u0 (
      .x16_BAUD(clk), .reset(rst_n), .Di(di), .load(ld[0]),
      .ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]));
   uart_tx #(.P_STOP_BITS(1), .P_PARITY_EN(1), .P_PARITY_ODD(0)) u1 (
      .x16_BAUD(clk), .reset(rst_n), .Di(di), .load(ld[1]),
      .ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]));
   uart_tx #(.P_STOP_BITS(1), .P_PARITY_EN(1), .P_PARITY_ODD(1)) u2 (
      .x16_BAUD(clk), .reset(rst_n), .Di(di), .load(ld[2]),
      .ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]));
   uart_tx #(.P_STOP_BITS(2), .P_PARITY_EN(0), .P_PARITY_ODD(0)) u3 (
      .x16_BAUD(clk), .reset(rst_n), .Di(di), .load(ld[3]),
      .ready(rdy[3]), .serial_out(so[3]), .busy(bsy[3]));

   int checks = 0;
   int errs   = 0;
   bit exp_q[$];
   bit samp[32];

   typedef struct {
      int         cfg;
      logic [7:0] d;
      int         exp_len;
      bit         has_par;
      bit         exp_par;
   } vec_t;
   vec_t tv[6];

   task automatic check(input string nm, input bit ok, input string info);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: %s", nm, info);
      end
   endtask

   function automatic int cfg_stops(input int cfg);
      return (cfg == 3) ? 2 : 1;
   endfunction
   function automatic bit cfg_pen(input int cfg);
      return (cfg == 1 || cfg == 2);
   endfunction
   function automatic bit cfg_odd(input int cfg);
      return (cfg == 2);
   endfunction

   // Frame as a list of bit levels, each held 16 cycles on the line.
   task automatic add_frame(input int cfg, input logic [7:0] d);
      int ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (cfg_pen(cfg)) exp_q.push_back(((ones % 2) != 0) ^ cfg_odd(cfg));
      for (int i = 0; i < cfg_stops(cfg); i++) exp_q.push_back(1'b1);
   endtask

   function automatic logic [7:0] rx_byte();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = samp[i + 1];
      return b;
   endfunction

   // Call right after driving the load at a negedge; cycle 1 is the first negedge
   // after the accepting edge. Checks every cycle up to one past the expected end.
   task automatic watch(input int cfg, input int flen, input string nm, input int hold_until,
                        input int ld_on, input int di_at, input logic [7:0] di_new,
                        output int len);
      int total = exp_q.size() * 16;
      int m_so = 0, m_rd = 0, m_bz = 0, first = 0;
      bit e_so, e_rd, e_bz;
      len = -1;
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge clk);
         e_so = (c <= total) ? exp_q[(c - 1) / 16] : 1'b1;
         e_rd = (c > total) || (c % flen == 0);
         e_bz = (c <= total);
         if (so[cfg] !== e_so) begin
            if (m_so == 0) first = c;
            m_so++;
         end
         if (rdy[cfg] !== e_rd) m_rd++;
         if (bsy[cfg] !== e_bz) m_bz++;
         if (len < 0 && bsy[cfg] === 1'b0) len = c - 1;
         if ((c - 1) % 16 == 7 && (c - 1) / 16 < 32) samp[(c - 1) / 16] = so[cfg];
         if (c == hold_until) ld[cfg] = 1'b0;
         if (c == ld_on) ld[cfg] = 1'b1;
         if (ld_on > 0 && c == ld_on + 1) ld[cfg] = 1'b0;
         if (c == di_at) di = di_new;
      end
      if (len < 0) len = total + 1;
      check({nm, "_line"}, m_so == 0, $sformatf("%0d bad cycles, first at %0d, wanted 0", m_so, first));
      check({nm, "_ready"}, m_rd == 0, $sformatf("%0d bad cycles, wanted 0", m_rd));
      check({nm, "_busy"}, m_bz == 0, $sformatf("%0d bad cycles, wanted 0", m_bz));
   endtask

   task automatic start(input int cfg, input logic [7:0] d);
      @(negedge clk);
      di      = d;
      ld[cfg] = 1'b1;
   endtask

   initial begin
      int len, m;
      logic [7:0] d;
      int cfg;

      tv[0] = '{0, 8'h55, 160, 1'b0, 1'b0};
      tv[1] = '{1, 8'hA3, 176, 1'b1, 1'b0};
      tv[2] = '{2, 8'hA3, 176, 1'b1, 1'b1};
      tv[3] = '{3, 8'h80, 176, 1'b0, 1'b0};
      tv[4] = '{0, 8'hFF, 160, 1'b0, 1'b0};
      tv[5] = '{2, 8'h00, 176, 1'b1, 1'b1};

      rst_n = 1'b0; ld = '0; di = '0;
      repeat (3) @(negedge clk);
      check("rst_line", so === 4'hF, $sformatf("got %b, wanted 1111", so));
      check("rst_ready", rdy === 4'hF, $sformatf("got %b, wanted 1111", rdy));
      check("rst_busy", bsy === 4'h0, $sformatf("got %b, wanted 0000", bsy));
      rst_n = 1'b1;
      m = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (so !== 4'hF || rdy !== 4'hF || bsy !== 4'h0) m++;
      end
      check("idle_200", m == 0, $sformatf("%0d bad cycles, wanted 0", m));

      foreach (tv[i]) begin
         exp_q.delete();
         add_frame(tv[i].cfg, tv[i].d);
         start(tv[i].cfg, tv[i].d);
         watch(tv[i].cfg, tv[i].exp_len, $sformatf("vec%0d", i), 1, 0, 0, 8'h00, len);
         check($sformatf("vec%0d_len", i), len == tv[i].exp_len,
               $sformatf("got %0d, wanted %0d", len, tv[i].exp_len));
         check($sformatf("vec%0d_rx", i), rx_byte() == tv[i].d,
               $sformatf("got %02h, wanted %02h", rx_byte(), tv[i].d));
         if (tv[i].has_par)
            check($sformatf("vec%0d_par", i), samp[9] == tv[i].exp_par,
                  $sformatf("got %0b, wanted %0b", samp[9], tv[i].exp_par));
      end

      // Back-to-back: load held high across the final stop cycle, Di switched after first accept.
      exp_q.delete();
      add_frame(0, 8'h00);
      add_frame(0, 8'hFF);
      start(0, 8'h00);
      watch(0, 160, "b2b", 161, 0, 1, 8'hFF, len);
      check("b2b_len", len == 320, $sformatf("got %0d, wanted 320", len));

      // Load pulse mid-DATA with new Di must be ignored.
      exp_q.delete();
      add_frame(0, 8'h12);
      start(0, 8'h12);
      watch(0, 160, "busyload", 1, 50, 50, 8'h34, len);
      check("busyload_rx", rx_byte() == 8'h12, $sformatf("got %02h, wanted 12", rx_byte()));
      check("busyload_len", len == 160, $sformatf("got %0d, wanted 160", len));

      // Asynchronous reset at cycle 70, then a clean frame.
      start(0, 8'h5A);
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (c == 1) ld[0] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_async", so[0] === 1'b1 && rdy[0] === 1'b1 && bsy[0] === 1'b0,
            $sformatf("got so=%b rdy=%b busy=%b, wanted 1 1 0", so[0], rdy[0], bsy[0]));
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      add_frame(0, 8'h0F);
      start(0, 8'h0F);
      watch(0, 160, "postrst", 1, 0, 0, 8'h00, len);
      check("postrst_rx", rx_byte() == 8'h0F, $sformatf("got %02h, wanted 0f", rx_byte()));

      // Simultaneous reset and load: nothing captured.
      @(negedge clk);
      rst_n = 1'b0; ld[0] = 1'b1; di = 8'hC3;
      @(negedge clk);
      ld[0] = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      check("rst_load", bsy[0] === 1'b0 && so[0] === 1'b1,
            $sformatf("got busy=%b so=%b, wanted 0 1", bsy[0], so[0]));

      for (int r = 0; r < 16; r++) begin
         cfg = int'($urandom_range(0, 3));
         d   = 8'($urandom);
         exp_q.delete();
         add_frame(cfg, d);
         start(cfg, d);
         watch(cfg, exp_q.size() * 16, $sformatf("rnd%0d", r), 1, 0, 2, 8'($urandom), len);
         check($sformatf("rnd%0d_rx", r), rx_byte() == d,
               $sformatf("got %02h, wanted %02h", rx_byte(), d));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the upstream stage of UART_RX across the serial line.
- Accepts a byte over a valid/ready handshake and serialises it as a standard asynchronous frame, LSB first.
- Framing: start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
- Clocked by the same x16-oversampled baud clock as UART_RX: one bit period = 16 x16_BAUD cycles.

Parameters:
- P_STOP_BITS, 1, number of stop bits (legal values 1 or 2).
- P_PARITY_EN, 0, 1 = insert parity bit after data bit 7.
- P_PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when P_PARITY_EN=0).

Ports:
- x16_BAUD  input  1  clock, 16x bit rate, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Di  input  8  byte to transmit; sampled only on acceptance.
- load  input  1  request to send Di.
- ready  output  1  block can accept a byte this cycle.
- serial_out  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress.

Behaviour:
- Reset (reset=0, asynchronous): serial_out=1, ready=1, busy=0, state=IDLE, tick and bit counters=0, shift register=0. Takes effect immediately, including mid-frame; no partial frame resumes after release.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: load=1 and ready=1 at a rising edge N. Di is captured into the shift register, state goes to START.
  - serial_out=0 from edge N through edge N+16 (16 cycles).
  - busy=1 from edge N.
- load while ready=0: ignored; Di is not captured and the current frame is unaffected.
- Tick counter (4-bit): counts 0..15 in every non-IDLE state. The state/bit advance happens when the tick counter wraps 15->0.
- DATA: 8 bits, each 16 cycles. serial_out = shift register bit 0, shifted right at each bit boundary. The bit index counts 0..7.
- PARITY: present only if P_PARITY_EN=1; 16 cycles.
  - Value = XOR of the 8 captured bits, XOR P_PARITY_ODD.
  - Computed from the captured byte, not from live Di.
- STOP: serial_out=1 for 16*P_STOP_BITS cycles.
- Frame length: exactly 16*(1+8+P_PARITY_EN+P_STOP_BITS) cycles from acceptance edge to frame end. Default configuration: 160 cycles.
- ready: 1 in IDLE, and also during the final cycle of the final stop bit (tick=15, last stop bit); 0 otherwise.
- Back-to-back frames: a load accepted in that final stop cycle moves the state directly from STOP to START. The next start bit follows with zero idle cycles.
- Frame end without load: state returns to IDLE, busy=0 on the following cycle, serial_out stays 1.
- Simultaneous reset and load: reset wins; nothing is captured.
- Glitches: serial_out is driven from a flop, never from combinational decode.

Test Plan:
- Reset then idle 200 cycles -> serial_out=1, ready=1, busy=0 throughout.
- Default params, load Di=0x55 once -> serial_out holds each level for 16 cycles: 0, then 1,0,1,0,1,0,1,0, then 1. ready returns in cycle 160 after acceptance; busy drops after frame end.
- P_PARITY_EN=1, P_PARITY_ODD=0, Di=0xA3 -> data bits 1,1,0,0,0,1,0,1, then parity bit 0. With P_PARITY_ODD=1 -> parity bit 1. Frame length 176 cycles.
- Back-to-back load 0x00 then 0xFF, with load held high -> second start bit begins the cycle after the first frame's last stop cycle. No extra idle cycle; total 320 cycles.
- Load 0x12 while busy (mid-DATA), with Di changed to 0x34 -> frame still carries 0x12; 0x34 is not transmitted.
- Reset asserted at cycle 70 of a frame -> serial_out=1 and ready=1 in the same cycle. After release, a new load of 0x0F produces a full clean frame.
- Loopback, default params: serial_out drives UART_RX serial_in on a shared x16_BAUD, send 0x00, 0x5A, 0xFF -> UART_RX Do matches each byte, valid pulses once per frame, error=0.
